// File: rtl/trace_pkg.sv
// Shared types and helpers for the trace_capture logic analyser.
package trace_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE_FILL,
        WAIT_TRIG,
        POST,
        DONE
    } state_t;

    localparam int DEF_CH    = 6;
    localparam int DEF_DEPTH = 64;
    localparam int AW        = $clog2(DEF_DEPTH);
    localparam int CW        = $clog2(DEF_CH);

    // Bit offset of a channel inside the flattened probe bus; out-of-range selects fall back to channel 0.
    function automatic int unsigned chLsb(input int unsigned sel, input int unsigned numCh,
                                          input int unsigned chW);
        return (sel < numCh) ? sel * chW : 0;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port sample store: one write port, one registered read port (M10K-friendly).
module trace_ram
    import trace_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int DW    = 96,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/trace_capture.sv
// Probe logic analyser: circular capture with pre-trigger window, masked trigger, freeze for readout.
module trace_capture
    import trace_pkg::*;
#(
    parameter int CH    = 6,
    parameter int W     = 16,
    parameter int DEPTH = 64,
    parameter int PRE   = 16
) (
    input  logic                     CLK1_50,
    input  logic                     RST,
    input  logic [CH*W-1:0]          PROBE,
    input  logic                     SAMPLE_EN,
    input  logic                     ARM,
    input  logic [$clog2(CH)-1:0]    TRIG_CH,
    input  logic [W-1:0]             TRIG_VAL,
    input  logic [W-1:0]             TRIG_MASK,
    input  logic [$clog2(DEPTH)-1:0] RD_ADDR,
    input  logic [$clog2(CH)-1:0]    RD_CH,
    output logic [W-1:0]             RD_DATA,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [$clog2(DEPTH)-1:0] TRIG_POS
);

    localparam int AddrW = $clog2(DEPTH);
    localparam int ChW   = $clog2(CH);
    localparam logic [AddrW-1:0] PreCnt  = AddrW'(PRE);
    localparam logic [AddrW-1:0] PostCnt = AddrW'(DEPTH - PRE - 1);

    state_t            state_q;
    logic [AddrW-1:0]  wptr_q;
    logic [AddrW-1:0]  cnt_q;
    logic [AddrW-1:0]  trigPos_q;
    logic              busy_q;
    logic              done_q;
    logic              rdZero_q;
    logic [ChW-1:0]    rdCh_q;

    logic              writeEn;
    logic              hit;
    logic [W-1:0]      trigSample;
    logic [AddrW-1:0]  cntInc;
    logic [AddrW-1:0]  rdPhys;
    logic [CH*W-1:0]   rdRow;

    // An ARM in a capturing state discards that cycle's sample.
    always_comb begin
        writeEn    = (state_q inside {PRE_FILL, WAIT_TRIG, POST}) && SAMPLE_EN && !ARM && !RST;
        trigSample = PROBE[chLsb(32'(TRIG_CH), CH, W) +: W];
        hit        = SAMPLE_EN && (((trigSample ^ TRIG_VAL) & TRIG_MASK) == '0);
        cntInc     = cnt_q + 1'b1;
        rdPhys     = trigPos_q - PreCnt + RD_ADDR;
    end

    always_ff @(posedge CLK1_50) begin
        if (RST) begin
            state_q   <= IDLE;
            wptr_q    <= '0;
            cnt_q     <= '0;
            trigPos_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (ARM) begin
            state_q <= PRE_FILL;
            wptr_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else if (writeEn) begin
            wptr_q <= wptr_q + 1'b1;
            unique case (state_q)
                PRE_FILL: begin
                    cnt_q <= cntInc;
                    if (cntInc == PreCnt) begin
                        state_q <= WAIT_TRIG;
                    end
                end
                WAIT_TRIG: begin
                    if (hit) begin
                        trigPos_q <= wptr_q;
                        cnt_q     <= '0;
                        state_q   <= POST;
                    end
                end
                POST: begin
                    cnt_q <= cntInc;
                    if (cntInc == PostCnt) begin
                        state_q <= trace_pkg::DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Channel select is applied after the RAM register, so the channel index is delayed to match.
    always_ff @(posedge CLK1_50) begin
        if (RST) begin
            rdZero_q <= 1'b1;
            rdCh_q   <= '0;
        end else begin
            rdZero_q <= 1'b0;
            rdCh_q   <= RD_CH;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .DW    (CH * W)
    ) uRam (
        .clk_i   (CLK1_50),
        .we_i    (writeEn),
        .waddr_i (wptr_q),
        .wdata_i (PROBE),
        .raddr_i (rdPhys),
        .rdata_o (rdRow)
    );

    assign RD_DATA  = rdZero_q ? '0 : rdRow[chLsb(32'(rdCh_q), CH, W) +: W];
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign TRIG_POS = trigPos_q;

endmodule

// File: tb/tb_trace_capture.sv
// Scoreboard bench for trace_capture: directed captures, expected values queued and checked by a monitor.
module tb_trace_capture;

    localparam int K_RD   = 0;
    localparam int K_BUSY = 1;
    localparam int K_DONE = 2;
    localparam int K_TPOS = 3;

    logic        CLK1_50 = 1'b0;
    logic        RST;
    logic [95:0] PROBE;
    logic        SAMPLE_EN;
    logic        ARM;
    logic [2:0]  TRIG_CH;
    logic [15:0] TRIG_VAL;
    logic [15:0] TRIG_MASK;
    logic [5:0]  RD_ADDR;
    logic [2:0]  RD_CH;
    logic [15:0] RD_DATA;
    logic        BUSY;
    logic        DONE;
    logic [5:0]  TRIG_POS;

    typedef struct {
        string       name;
        int          kind;
        logic [15:0] expVal;
    } chk_t;

    chk_t expQ[$];
    int   checks    = 0;
    int   errors    = 0;
    bit   req       = 1'b0;
    bit   pend      = 1'b0;
    bit   finishReq = 1'b0;

    trace_capture #(.CH(6), .W(16), .DEPTH(64), .PRE(16)) dut (
        .CLK1_50   (CLK1_50),
        .RST       (RST),
        .PROBE     (PROBE),
        .SAMPLE_EN (SAMPLE_EN),
        .ARM       (ARM),
        .TRIG_CH   (TRIG_CH),
        .TRIG_VAL  (TRIG_VAL),
        .TRIG_MASK (TRIG_MASK),
        .RD_ADDR   (RD_ADDR),
        .RD_CH     (RD_CH),
        .RD_DATA   (RD_DATA),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .TRIG_POS  (TRIG_POS)
    );

    always #10 CLK1_50 = ~CLK1_50;

    function automatic logic [95:0] mkProbe(input int ch, input logic [15:0] v);
        logic [95:0] p;
        p = '0;
        p[ch*16 +: 16] = v;
        return p;
    endfunction

    task automatic applyStimulus(input logic en, input logic arm, input logic [95:0] probe);
        SAMPLE_EN = en;
        ARM       = arm;
        PROBE     = probe;
        @(posedge CLK1_50);
        #1;
        SAMPLE_EN = 1'b0;
        ARM       = 1'b0;
    endtask

    task automatic checkOutput(input string name, input int kind, input logic [15:0] expVal,
                               input logic [5:0] addr, input logic [2:0] ch);
        chk_t c;
        RD_ADDR  = addr;
        RD_CH    = ch;
        c.name   = name;
        c.kind   = kind;
        c.expVal = expVal;
        expQ.push_back(c);
        req = 1'b1;
        @(posedge CLK1_50);
        #1;
    endtask

    // Monitor: a request made in one cycle is compared at the negedge after the following posedge.
    initial begin
        chk_t        c;
        logic [15:0] act;
        forever begin
            @(negedge CLK1_50);
            if (pend) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL scoreboard_underflow: no expected entry queued");
                end else begin
                    c = expQ.pop_front();
                    case (c.kind)
                        K_RD:    act = RD_DATA;
                        K_BUSY:  act = {15'd0, BUSY};
                        K_DONE:  act = {15'd0, DONE};
                        default: act = {10'd0, TRIG_POS};
                    endcase
                    if (act !== c.expVal) begin
                        errors++;
                        $display("[TB] FAIL %s: got %h, expected %h", c.name, act, c.expVal);
                    end
                end
            end
            pend = req;
            req  = 1'b0;
            if (finishReq && !pend) begin
                checks++;
                if (expQ.size() != 0) begin
                    errors++;
                    $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
                end
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin
        RST       = 1'b1;
        SAMPLE_EN = 1'b0;
        ARM       = 1'b0;
        PROBE     = '0;
        TRIG_CH   = 3'd0;
        TRIG_VAL  = 16'd0;
        TRIG_MASK = 16'hFFFF;
        RD_ADDR   = '0;
        RD_CH     = '0;

        // Reset defaults
        repeat (3) @(posedge CLK1_50);
        #1;
        checkOutput("rst_busy", K_BUSY, 16'd0, 6'd0, 3'd0);
        checkOutput("rst_done", K_DONE, 16'd0, 6'd0, 3'd0);
        checkOutput("rst_rd",   K_RD,   16'd0, 6'd0, 3'd0);
        checkOutput("rst_tpos", K_TPOS, 16'd0, 6'd0, 3'd0);
        RST = 1'b0;

        // Basic capture, trigger on counter value 40
        TRIG_CH = 3'd0; TRIG_VAL = 16'd40; TRIG_MASK = 16'hFFFF;
        applyStimulus(1'b0, 1'b1, '0);
        for (int n = 0; n < 87; n++) applyStimulus(1'b1, 1'b0, mkProbe(0, 16'(n)));
        checkOutput("t2_done_early", K_DONE, 16'd0, 6'd0, 3'd0);
        applyStimulus(1'b1, 1'b0, mkProbe(0, 16'd87));
        checkOutput("t2_done", K_DONE, 16'd1,  6'd0, 3'd0);
        checkOutput("t2_busy", K_BUSY, 16'd0,  6'd0, 3'd0);
        checkOutput("t2_tpos", K_TPOS, 16'd40, 6'd0, 3'd0);
        for (int a = 0; a < 64; a++)
            checkOutput($sformatf("t2_rd%0d", a), K_RD, 16'(24 + a), 6'(a), 3'd0);

        // Trigger value below PRE: ignored in pre-fill, hits after wrap; TRIG_CH=7 falls back to ch0
        TRIG_CH = 3'd7; TRIG_VAL = 16'd5; TRIG_MASK = 16'h003F;
        applyStimulus(1'b0, 1'b1, '0);
        for (int n = 0; n < 117; n++) applyStimulus(1'b1, 1'b0, mkProbe(0, 16'(n)));
        checkOutput("t3_done",  K_DONE, 16'd1,   6'd0,  3'd0);
        checkOutput("t3_tpos",  K_TPOS, 16'd5,   6'd0,  3'd0);
        checkOutput("t3_rd16",  K_RD,   16'd69,  6'd16, 3'd0);
        checkOutput("t3_rd0",   K_RD,   16'd53,  6'd0,  3'd0);
        checkOutput("t3_rd63",  K_RD,   16'd116, 6'd63, 3'd0);

        // Masked compare on channel 2
        TRIG_CH = 3'd2; TRIG_VAL = 16'h0003; TRIG_MASK = 16'h000F;
        applyStimulus(1'b0, 1'b1, '0);
        for (int n = 0; n < 77; n++) begin
            logic [15:0] c2;
            c2 = (n == 25) ? 16'hAB12 : (n == 29) ? 16'hAB13 : 16'h1230;
            if (n == 76) checkOutput("t4_done_early", K_DONE, 16'd0, 6'd0, 3'd0);
            applyStimulus(1'b1, 1'b0, mkProbe(0, 16'(n)) | mkProbe(2, c2));
        end
        checkOutput("t4_done",    K_DONE, 16'd1,     6'd0,  3'd0);
        checkOutput("t4_tpos",    K_TPOS, 16'd29,    6'd0,  3'd0);
        checkOutput("t4_rd16ch2", K_RD,   16'hAB13,  6'd16, 3'd2);
        checkOutput("t4_rd12ch2", K_RD,   16'hAB12,  6'd12, 3'd2);
        checkOutput("t4_rd15ch2", K_RD,   16'h1230,  6'd15, 3'd2);
        checkOutput("t4_rd16ch0", K_RD,   16'd29,    6'd16, 3'd0);

        // ARM during POST restarts the capture from slot 0
        TRIG_CH = 3'd0; TRIG_VAL = 16'd20; TRIG_MASK = 16'hFFFF;
        applyStimulus(1'b0, 1'b1, '0);
        for (int n = 0; n < 31; n++) applyStimulus(1'b1, 1'b0, mkProbe(0, 16'(n)));
        checkOutput("t5_busy_post", K_BUSY, 16'd1, 6'd0, 3'd0);
        TRIG_VAL = 16'd30;
        applyStimulus(1'b1, 1'b1, mkProbe(0, 16'hFFFF));
        checkOutput("t5_busy_rearm", K_BUSY, 16'd1, 6'd0, 3'd0);
        checkOutput("t5_done_rearm", K_DONE, 16'd0, 6'd0, 3'd0);
        for (int m = 0; m < 78; m++) applyStimulus(1'b1, 1'b0, mkProbe(0, 16'(m)));
        checkOutput("t5_done", K_DONE, 16'd1,  6'd0,  3'd0);
        checkOutput("t5_tpos", K_TPOS, 16'd30, 6'd0,  3'd0);
        checkOutput("t5_rd0",  K_RD,   16'd14, 6'd0,  3'd0);
        checkOutput("t5_rd63", K_RD,   16'd77, 6'd63, 3'd0);

        // RST in WAIT_TRIG aborts; later samples are not written
        TRIG_VAL = 16'd1000;
        applyStimulus(1'b0, 1'b1, '0);
        for (int n = 0; n < 20; n++) applyStimulus(1'b1, 1'b0, mkProbe(0, 16'(n)));
        RST = 1'b1;
        @(posedge CLK1_50);
        #1;
        RST = 1'b0;
        checkOutput("t5r_busy", K_BUSY, 16'd0, 6'd0, 3'd0);
        checkOutput("t5r_done", K_DONE, 16'd0, 6'd0, 3'd0);
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, mkProbe(0, 16'hDEAD));
        checkOutput("t5r_busy_idle", K_BUSY, 16'd0, 6'd0,  3'd0);
        checkOutput("t5r_tpos",      K_TPOS, 16'd0, 6'd0,  3'd0);
        checkOutput("t5r_slot0",     K_RD,   16'd0, 6'd16, 3'd0);
        checkOutput("t5r_slot4",     K_RD,   16'd4, 6'd20, 3'd0);

        // Sparse SAMPLE_EN with TRIG_MASK=0: first sample after pre-fill triggers
        TRIG_CH = 3'd1; TRIG_VAL = 16'h1234; TRIG_MASK = 16'h0000;
        applyStimulus(1'b0, 1'b1, '0);
        for (int k = 0; k < 64; k++) begin
            if (k == 63) checkOutput("t6_done_early", K_DONE, 16'd0, 6'd0, 3'd0);
            applyStimulus(1'b1, 1'b0, mkProbe(5, 16'(16'h5000 + k)));
            applyStimulus(1'b0, 1'b0, mkProbe(5, 16'hEEEE));
            applyStimulus(1'b0, 1'b0, mkProbe(5, 16'hEEEE));
        end
        checkOutput("t6_done", K_DONE, 16'd1,  6'd0, 3'd0);
        checkOutput("t6_tpos", K_TPOS, 16'd16, 6'd0, 3'd0);
        for (int a = 0; a < 64; a += 7)
            checkOutput($sformatf("t6_rd%0dch5", a), K_RD, 16'(16'h5000 + a), 6'(a), 3'd5);

        finishReq = 1'b1;
    end

endmodule
